// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the pattern_tx_11001 serial transmitter.
// Contents: FSM state enum, the 11001 default pattern and the counter widths.
package pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Pattern the downstream t_11001 detector looks for.
    localparam logic [4:0] PAT_11001 = 5'b11001;

    // Bit counter covers WIDTH up to 16; rep and gap are 4-bit fields.
    localparam int CNT_W = 4;
    localparam int REP_W = 4;
    localparam int GAP_W = 4;

endpackage

// File: rtl/pattern_tx_11001_piso_shreg.sv
// piso_shreg: WIDTH-bit parallel-load, shift-left register.
// Ports:
//   clk     - rising-edge clock
//   load_i  - load data_i (wins over shift_i)
//   shift_i - shift left by one, fill_i enters at the LSB
//   data_i  - parallel load value
//   fill_i  - serial fill bit
//   msb_o   - register MSB (a flop output)
module piso_shreg #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             fill_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] shreg_q;

    // NOTE: no reset here on purpose; the owner clears the contents by
    // loading the fill value, which keeps this a plain datapath register.
    always_ff @(posedge clk) begin
        if (load_i) begin
            shreg_q <= data_i;
        end else if (shift_i) begin
            // NOTE: non-blocking so every flop samples the pre-edge value.
            shreg_q <= {shreg_q[WIDTH-2:0], fill_i};
        end
    end

    assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/pattern_tx_11001.sv
// pattern_tx_11001: serial pattern transmitter feeding the t_11001 detector.
// Sends a WIDTH-bit pattern MSB-first, repeated rep+1 times with gap idle
// cycles between frames. All outputs come straight from flops.
// Ports:
//   clk, reset  - clock; synchronous active-low reset
//   start       - send request, honoured only in IDLE
//   use_ext     - 1: send pat_in, 0: send DEFAULT_PAT (latched with start)
//   pat_in      - external pattern (latched with start)
//   rep, gap    - frames-1 and inter-frame idle cycles (latched with start)
//   abort       - synchronous stop, no done pulse
//   x           - serial data out
//   busy        - high from first bit through last bit, gaps included
//   sof         - one-cycle pulse with the MSB of every frame
//   done        - one-cycle pulse in the cycle after the final bit
module pattern_tx_11001
    import pattern_tx_pkg::*;
#(
    parameter int               WIDTH       = 5,
    parameter logic [WIDTH-1:0] DEFAULT_PAT = WIDTH'(PAT_11001),
    parameter logic             IDLE_BIT    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             use_ext,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [REP_W-1:0] rep,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             x,
    output logic             busy,
    output logic             sof,
    output logic             done
);

    state_t           state_q;
    logic [WIDTH-1:0] pat_q;
    logic [CNT_W-1:0] bit_q;
    logic [REP_W-1:0] frame_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             busy_q;
    logic             sof_q;
    logic             done_q;

    logic             shreg_load;
    logic             shreg_shift;
    logic [WIDTH-1:0] shreg_data;
    logic [WIDTH-1:0] start_pat;

    assign start_pat = use_ext ? pat_in : DEFAULT_PAT;

    // Shift register control. Shifting in IDLE_BIT means the register drains
    // to IDLE_BIT after the last bit, so x needs no gating in GAP or IDLE.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        shreg_load  = 1'b0;
        shreg_shift = 1'b0;
        shreg_data  = pat_q;
        if (!reset || abort) begin
            shreg_load = 1'b1;
            shreg_data = {WIDTH{IDLE_BIT}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shreg_load = 1'b1;
                        shreg_data = start_pat;
                    end
                end
                ST_SHIFT: begin
                    // Back-to-back frames reload instead of draining.
                    if (bit_q == '0 && frame_q != '0 && gap_q == '0) begin
                        shreg_load = 1'b1;
                    end else begin
                        shreg_shift = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        shreg_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        sof_q  <= 1'b0;
        done_q <= 1'b0;
        if (!reset || abort) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            pat_q     <= '0;
            bit_q     <= '0;
            frame_q   <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pat_q   <= start_pat;
                        frame_q <= rep;
                        gap_q   <= gap;
                        bit_q   <= CNT_W'(WIDTH - 1);
                        busy_q  <= 1'b1;
                        sof_q   <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_q == '0) begin
                        if (frame_q == '0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            frame_q <= frame_q - 1'b1;
                            bit_q   <= CNT_W'(WIDTH - 1);
                            if (gap_q == '0) begin
                                sof_q <= 1'b1;
                            end else begin
                                gap_cnt_q <= gap_q - 1'b1;
                                state_q   <= ST_GAP;
                            end
                        end
                    end else begin
                        bit_q <= bit_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        sof_q   <= 1'b1;
                        state_q <= ST_SHIFT;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    piso_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .load_i  (shreg_load),
        .shift_i (shreg_shift),
        .data_i  (shreg_data),
        .fill_i  (IDLE_BIT),
        .msb_o   (x)
    );

    assign busy = busy_q;
    assign sof  = sof_q;
    assign done = done_q;

endmodule
